// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Load formats follow the RISC-V funct3 encodings.
package wb_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_COMMIT
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_load_align.sv
// Selects the addressed byte/half of a loaded word and sign/zero-extends it.
// Halfword selection uses offset[1] only; LW and unknown formats pass through.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(rdata >> {offset, 3'b000});
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){b[7]}}, b};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, b};
      F3_LH:   data = {{(DATA_WIDTH-16){h[15]}}, h};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/wb_unit.sv
// Writeback stage: retires one instruction per handshake into the register file.
// Define WB_FORWARD_EN to drive the fwd_* bypass outputs during the write cycle.
module wb_unit
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [ADDR_WIDTH-1:0]    in_rd,
  input  logic                     in_rd_wen,
  input  logic                     in_is_load,
  input  logic [2:0]               in_funct3,
  input  logic [DATA_WIDTH-1:0]    in_result,
  input  logic                     lsu_rvalid,
  input  logic [DATA_WIDTH-1:0]    lsu_rdata,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     commit_valid,
  output logic [DATA_WIDTH-1:0]    commit_pc,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic [ADDR_WIDTH-1:0]    busy_rd,
  output logic                     fwd_valid,
  output logic [ADDR_WIDTH-1:0]    fwd_rd,
  output logic [DATA_WIDTH-1:0]    fwd_data
);
  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    pc_q, data_q, ld_data;
  logic [ADDR_WIDTH-1:0]    rd_q;
  logic                     rd_wen_q;
  logic [2:0]               f3_q;
  logic [1:0]               off_q;
  logic [INSTRET_WIDTH-1:0] instret_q;
  logic                     xfer;

  assign in_ready = (state_q != S_WAIT_LOAD);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_COMMIT: begin
        if (xfer) state_d = in_is_load ? S_WAIT_LOAD : S_COMMIT;
        else      state_d = S_IDLE;
      end
      S_WAIT_LOAD: begin
        if (lsu_rvalid) state_d = S_COMMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  wb_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .funct3(f3_q),
    .offset(off_q),
    .rdata (lsu_rdata),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      instret_q <= '0;
    end else begin
      if (xfer) begin
        pc_q     <= in_pc;
        rd_q     <= in_rd;
        rd_wen_q <= in_rd_wen;
        f3_q     <= in_funct3;
        off_q    <= in_result[1:0];
        data_q   <= in_result;
      end else if (state_q == S_WAIT_LOAD && lsu_rvalid) begin
        data_q <= ld_data;
      end
      // count on entry so instret is already updated in the commit cycle
      if (state_d == S_COMMIT)
        instret_q <= instret_q + INSTRET_WIDTH'(1);
    end
  end

  assign commit_valid = (state_q == S_COMMIT);
  assign commit_pc    = pc_q;
  assign rf_wen       = commit_valid && rd_wen_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = data_q;
  assign instret      = instret_q;
  assign busy_rd      = (state_q != S_IDLE && rd_wen_q) ? rd_q : '0;

`ifdef WB_FORWARD_EN
  assign fwd_valid = commit_valid && rf_wen;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif
endmodule
